alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational 3-bit ALU between N_REQ requesters. Each requester issues
//  {op, a, b} over a valid/ready channel. A round-robin arbiter grants one request at a
//  time, drives the ALU from registered operands, and returns the registered result on
//  one shared response channel tagged with the requester id. Sits between the requesting
//  datapath blocks and the shared `alu` cell.
// PARAMETERS
//  N_REQ   2  number of requesters (2..8)
//  DATA_W  3  operand width; result width is DATA_W+1
//  ID_W    $clog2(N_REQ) (min 1)  width of rsp_id
// PORTS
//  clk        in   1              single clock, all state on posedge
//  rst        in   1              synchronous, active-high reset
//  req_valid  in   N_REQ          requester i has a request
//  req_ready  out  N_REQ          request i accepted this cycle
//  req_op     in   2*N_REQ        op of requester i at [2i+:2]
//  req_a      in   DATA_W*N_REQ   operand a of requester i
//  req_b      in   DATA_W*N_REQ   operand b of requester i
//  rsp_valid  out  1              response holds a result
//  rsp_ready  in   1              consumer accepts the response
//  rsp_id     out  ID_W           index of the requester that owns rsp_data
//  rsp_data   out  DATA_W+1       ALU result
//  busy       out  1              high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, busy=0.
//  - Ops: 00 a&b, 01 a|b, 10 a+b (carry goes to bit DATA_W), 11 ~a on DATA_W+1 bits,
//    i.e. {1'b1,~a}. AND and OR results are zero-extended.
//  - FSM IDLE -> EXEC -> RESP -> IDLE:
//    IDLE: grant g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//      If no valid, stay in IDLE. If valid, req_ready[g]=1 for this cycle only, which is the
//      handshake. Capture op/a/b/g into registers and go to EXEC.
//    EXEC: ALU en=1 with the captured operands. Register rsp_data and rsp_id, set
//      rsp_valid=1, and go to RESP. ALU en=0 in every other state.
//    RESP: hold rsp_valid, rsp_id and rsp_data stable until rsp_ready=1. On that cycle
//      clear rsp_valid, set rr_ptr=(g+1) mod N_REQ, and go to IDLE.
//  - req_ready is combinational from state, rr_ptr and req_valid. It is never high outside
//    IDLE, and at most one bit is high at a time (one-hot or zero).
//  - Latency: request accepted at cycle T gives rsp_valid at T+2. Peak throughput is one
//    op per 3 cycles.
//  - Requesters hold valid and payload stable until ready. Payload changes while valid is
//    held and not accepted are sampled only at acceptance.
//  - A requester dropping valid before grant is legal. It is simply not granted.
//  - rsp_ready held high in RESP: the response completes in one cycle. rsp_ready is
//    ignored outside RESP.
//  - rr_ptr advances only on response handshake, not on grant.
//  - Reset mid-operation, in any state: the in-flight op is discarded, no response is
//    issued, and all outputs go to their reset values on the next edge.
//  - rr_ptr wraps from N_REQ-1 to 0. A single active requester is granted every
//    IDLE visit.
// STRUCTURE
//  - alu_pkg: op codes (OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_NOT=2'b11) and the
//    state encoding (IDLE, EXEC, RESP).
//  - Sub-module rr_picker: purely combinational (req_vec, ptr -> grant_idx, grant_vld).
//  - The shared `alu` cell is instantiated once inside this block.
// TESTING
//  1. Single op: req0 {ADD,a=7,b=7} -> req_ready[0] at T, rsp_valid at T+2, rsp_data=4'hE,
//     rsp_id=0.
//  2. Op coverage via req1: AND 6&3=4'h2, OR 4|1=4'h5, NOT a=2 -> 4'hD, ADD 3+4=4'h7.
//  3. Fairness: both valid continuously, rsp_ready=1 -> grants 0,1,0,1. Each accept is
//     3 cycles apart.
//  4. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_id stable, busy=1,
//     no req_ready. Release -> rsp_valid drops next cycle.
//  5. Reset in EXEC: rst pulse -> no rsp_valid, rr_ptr=0, next grant goes to lowest
//     valid index.
//  6. Idle: no req_valid for 10 cycles -> state IDLE, busy=0, rsp_valid=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: op codes, FSM state encoding and id-width helper.
package alu_arbiter_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester id width: clog2 of the requester count, never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU cell: AND/OR/ADD/NOT producing a DATA_W+1 bit result.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 3
) (
  input  logic              en,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   result_c
);

  // Result is forced to zero when the cell is not enabled.
  always_comb begin
    result_c = '0;
    if (en) begin
      case (op_e'(op))
        OP_AND:  result_c = {1'b0, a & b};
        OP_OR:   result_c = {1'b0, a | b};
        OP_ADD:  result_c = {1'b0, a} + {1'b0, b};
        OP_NOT:  result_c = {1'b1, ~a};
        default: result_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: first set bit of req_vec scanning ptr, ptr+1, ... modulo N_REQ.
module rr_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_vec,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_vld
);

  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % N_REQ);
      if (!grant_vld && req_vec[idx]) begin
        grant_idx = idx;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters; one op in flight,
// result returned on a single tagged response channel.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned DATA_W = 3,
  parameter int unsigned ID_W   = id_width(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [OP_W*N_REQ-1:0]    req_op,
  input  logic [DATA_W*N_REQ-1:0]  req_a,
  input  logic [DATA_W*N_REQ-1:0]  req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W:0]          rsp_data,
  output logic                     busy
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_e            state;
  state_e            state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_vld;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [ID_W-1:0]   g_q;
  logic              alu_en;
  logic [DATA_W:0]   alu_result;

  logic [OP_W-1:0]   op_arr [N_REQ];
  logic [DATA_W-1:0] a_arr  [N_REQ];
  logic [DATA_W-1:0] b_arr  [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[OP_W*i +: OP_W];
    assign a_arr[i]  = req_a[DATA_W*i +: DATA_W];
    assign b_arr[i]  = req_b[DATA_W*i +: DATA_W];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_vec   (req_valid),
    .ptr       (rr_ptr),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .en       (alu_en),
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result_c (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_vld) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant handshake is only offered while idle; the ALU is only enabled in EXEC.
  always_comb begin
    req_ready = '0;
    alu_en    = 1'b0;
    case (state)
      IDLE:    if (grant_vld) req_ready[grant_idx] = 1'b1;
      EXEC:    alu_en = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, response registers and fairness pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      g_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_q <= op_arr[grant_idx];
            a_q  <= a_arr[grant_idx];
            b_q  <= b_arr[grant_idx];
            g_q  <= grant_idx;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_id    <= g_q;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (g_q == LAST_ID) ? '0 : g_q + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (N_REQ=2, DATA_W=3): vector table, directed
// corner sequences and randomized rounds against a transaction-level model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_op;
  logic [5:0] req_a;
  logic [5:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [0:0] rsp_id;
  logic [3:0] rsp_data;
  logic       busy;

  logic [1:0] t_op [2];
  logic [2:0] t_a  [2];
  logic [2:0] t_b  [2];

  assign req_op = {t_op[1], t_op[0]};
  assign req_a  = {t_a[1], t_a[0]};
  assign req_b  = {t_b[1], t_b[0]};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.N_REQ(2), .DATA_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct {
    int id;
    int op;
    int a;
    int b;
    int exp;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from the op definitions using plain integer arithmetic.
  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a + b;
      default: return 15 - a;
    endcase
  endfunction

  function automatic int pick(input int ptr, input int mask);
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (ptr + k) % 2;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic wait_accept(input int id, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (req_ready[id]) begin
        ok = 1'b1;
        t  = cyc;
      end else begin
        tick();
      end
    end
  endtask

  task automatic wait_rsp(output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        t  = cyc;
      end else begin
        tick();
      end
    end
  endtask

  task automatic txn(input int id, input int op, input int a, input int b,
                     input int exp, input string nm);
    int ta, tr;
    bit ok;
    t_op[id] = 2'(op);
    t_a[id]  = 3'(a);
    t_b[id]  = 3'(b);
    req_valid[id] = 1'b1;
    wait_accept(id, ta, ok);
    check({nm, "_accept"}, int'(ok), 1);
    tick();
    req_valid[id] = 1'b0;
    wait_rsp(tr, ok);
    check({nm, "_rsp_seen"}, int'(ok), 1);
    check({nm, "_latency"}, tr - ta, 2);
    check({nm, "_data"}, int'(rsp_data), exp);
    check({nm, "_id"}, int'(rsp_id), id);
    tick();
    check({nm, "_rsp_drop"}, int'(rsp_valid), 0);
    model_ptr = (id + 1) % 2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int   gq [$];
    int   tq [$];

    vecs[0] = '{id: 0, op: 2, a: 7, b: 7, exp: 14};
    vecs[1] = '{id: 1, op: 0, a: 6, b: 3, exp: 2};
    vecs[2] = '{id: 1, op: 1, a: 4, b: 1, exp: 5};
    vecs[3] = '{id: 1, op: 3, a: 2, b: 0, exp: 13};
    vecs[4] = '{id: 1, op: 2, a: 3, b: 4, exp: 7};
    vecs[5] = '{id: 0, op: 3, a: 7, b: 0, exp: 8};
    vecs[6] = '{id: 1, op: 0, a: 0, b: 7, exp: 0};

    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      t_op[i] = '0; t_a[i] = '0; t_b[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_req_ready", int'(req_ready), 0);
    check("reset_rsp_id", int'(rsp_id), 0);
    check("reset_rsp_data", int'(rsp_data), 0);
    tick();

    // Vector table: single-op latency and op coverage.
    for (int i = 0; i < 7; i++)
      txn(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Backpressure: response must hold stable while rsp_ready is low.
    begin
      int ta, tr;
      bit ok;
      rsp_ready = 1'b0;
      t_op[0] = 2'd2; t_a[0] = 3'd5; t_b[0] = 3'd1;
      req_valid[0] = 1'b1;
      wait_accept(0, ta, ok);
      check("bp_accept", int'(ok), 1);
      tick();
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b1;
      wait_rsp(tr, ok);
      check("bp_rsp_seen", int'(ok), 1);
      for (int k = 0; k < 5; k++) begin
        #1;
        check($sformatf("bp_data%0d", k), int'(rsp_data), 6);
        check($sformatf("bp_id%0d", k), int'(rsp_id), 0);
        check($sformatf("bp_busy%0d", k), int'(busy), 1);
        check($sformatf("bp_ready%0d", k), int'(req_ready), 0);
        check($sformatf("bp_valid%0d", k), int'(rsp_valid), 1);
        tick();
      end
      rsp_ready = 1'b1;
      req_valid[1] = 1'b0;
      tick();
      check("bp_release_valid", int'(rsp_valid), 0);
      check("bp_release_busy", int'(busy), 0);
      model_ptr = 1;
    end

    // Reset during EXEC: in-flight op discarded, pointer back to 0.
    begin
      int ta, tr;
      bit ok;
      t_op[0] = 2'd0; t_a[0] = 3'd5; t_b[0] = 3'd6;
      t_op[1] = 2'd1; t_a[1] = 3'd1; t_b[1] = 3'd2;
      req_valid = 2'b11;
      #1;
      check("rst_pre_grant", int'(req_ready), 2);
      tick();
      check("rst_exec_busy", int'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_lowest_grant", int'(req_ready), 1);
      wait_accept(0, ta, ok);
      check("rst_accept", int'(ok), 1);
      tick();
      req_valid = 2'b00;
      wait_rsp(tr, ok);
      check("rst_rsp_seen", int'(ok), 1);
      check("rst_rsp_id", int'(rsp_id), 0);
      check("rst_rsp_data", int'(rsp_data), 4);
      tick();
      model_ptr = 1;
    end

    // Fairness: both requesters valid continuously, consumer always ready.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    req_valid = 2'b11;
    for (int k = 0; k < 14; k++) begin
      #1;
      if (req_ready != 2'b00) begin
        gq.push_back(req_ready[1] ? 1 : 0);
        tq.push_back(cyc);
      end
      tick();
    end
    req_valid = 2'b00;
    check("fair_grant_count", gq.size(), 5);
    for (int i = 0; i < gq.size() && i < 5; i++) begin
      int g;
      g = pick(model_ptr, 3);
      check($sformatf("fair_grant%0d", i), gq[i], g);
      model_ptr = (g + 1) % 2;
      if (i > 0) check($sformatf("fair_gap%0d", i), tq[i] - tq[i-1], 3);
    end
    for (int k = 0; k < 4; k++) tick();

    // Idle: nothing requested, nothing happens.
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("idle_busy%0d", k), int'(busy), 0);
      check($sformatf("idle_rsp%0d", k), int'(rsp_valid), 0);
      check($sformatf("idle_ready%0d", k), int'(req_ready), 0);
      tick();
    end

    // Randomized rounds against the transaction-level model.
    for (int r = 0; r < 40; r++) begin
      int mask, g, exp, ta, tr, d;
      bit ok;
      mask = int'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        t_op[i] = 2'($urandom);
        t_a[i]  = 3'($urandom);
        t_b[i]  = 3'($urandom);
      end
      req_valid = 2'(mask);
      g = pick(model_ptr, mask);
      exp = ref_alu(int'(t_op[g]), int'(t_a[g]), int'(t_b[g]));
      wait_accept(g, ta, ok);
      check($sformatf("rnd%0d_accept", r), int'(ok), 1);
      check($sformatf("rnd%0d_onehot", r), int'(req_ready), 1 << g);
      tick();
      req_valid = 2'b00;
      for (int i = 0; i < 2; i++) begin
        t_op[i] = 2'($urandom);
        t_a[i]  = 3'($urandom);
        t_b[i]  = 3'($urandom);
      end
      wait_rsp(tr, ok);
      check($sformatf("rnd%0d_latency", r), tr - ta, 2);
      check($sformatf("rnd%0d_data", r), int'(rsp_data), exp);
      check($sformatf("rnd%0d_id", r), int'(rsp_id), g);
      d = int'($urandom_range(0, 3));
      for (int j = 0; j < d; j++) begin
        rsp_ready = 1'b0;
        #1;
        check($sformatf("rnd%0d_hold%0d", r, j), int'(rsp_data), exp);
        tick();
      end
      rsp_ready = 1'b1;
      tick();
      check($sformatf("rnd%0d_drop", r), int'(rsp_valid), 0);
      model_ptr = (g + 1) % 2;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
